lab3_keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, debounces press and release, and produces the registered key code plus a one-cycle new-key strobe. It sits directly upstream of the two-digit display controller: `keypress` and `alarm` feed that stage's `keypress` and `alarm` inputs, which shift the new code into the current digit and move the old one to the past digit. Raw row inputs come from keypad pins with pull-ups; the column outputs drive keypad pins.

---
 rtl/lab3_kp_pkg.sv | 25 ++
 rtl/lab3_kp_sync.sv | 27 ++
 rtl/lab3_keypad_scanner.sv | 164 ++++++++++++++++
 tb/tb_lab3_keypad_scanner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state enum, the first column drive and the idle key code.
package lab3_kp_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } kp_state_t;

    localparam logic [3:0] COL_FIRST = 4'b1110;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when exactly one active-low row is pulled down.
    function automatic logic one_low(input logic [3:0] r);
        return $countones(~r) == 1;
    endfunction

endpackage

// File: rtl/lab3_kp_sync.sv
// Two-flop synchronizer for raw keypad rows; resets to all-ones (idle).
// Ports: i_clk, i_rst_n (async, active-low), i_d[W], o_q[W].
module lab3_kp_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lab3_keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, key strobe.
// Ports: int_osc clock, reset (async, active-low), rows[4] in (active-low),
// cols[4] out (active-low one-hot), keypress[8] {row,col}, alarm strobe.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module lab3_keypad_scanner
    import lab3_kp_pkg::*;
#(
    parameter int SCAN_DIV     = 24000,
    parameter int DEBOUNCE_CYC = 480000,
    parameter int REPEAT_CYC   = 4800000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] keypress,
    output logic       alarm
);

    localparam int SW = cnt_w(SCAN_DIV);
    localparam int DW = cnt_w(DEBOUNCE_CYC);
    localparam logic [SW-1:0] DIV_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC - 1);

    kp_state_t     r_state;
    kp_state_t     w_next;
    logic [3:0]    w_rows_s;
    logic [SW-1:0] r_div;
    logic [DW-1:0] r_db;
    logic [3:0]    r_cols;
    logic [7:0]    r_cand;
    logic [7:0]    r_keypress;
    logic          r_alarm;

    logic w_tick;
    logic w_one;
    logic w_idle;
    logic w_match;
    logic w_db_max;
    logic w_adv;
    logic w_latch;
    logic w_accept;
    logic w_db_clr;
    logic w_db_inc;
    logic w_rep_fire;

    lab3_kp_sync #(.W(4)) u_sync (
        .i_clk   (int_osc),
        .i_rst_n (reset),
        .i_d     (rows),
        .o_q     (w_rows_s)
    );

    assign w_tick   = (r_state == SCAN) && (r_div == DIV_MAX);
    assign w_one    = one_low(w_rows_s);
    assign w_idle   = &w_rows_s;
    assign w_match  = (w_rows_s == ~r_cand[7:4]);
    assign w_db_max = (r_db == DB_MAX);

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) r_state <= SCAN;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SCAN:     if (w_tick && w_one) w_next = PRESS_DB;
            PRESS_DB: if (!w_match)        w_next = SCAN;
                      else if (w_db_max)   w_next = HELD;
            HELD:     if (w_idle)          w_next = REL_DB;
            REL_DB:   if (w_idle && w_db_max) w_next = SCAN;
            default:  w_next = SCAN;
        endcase
    end

    always_comb begin
        w_adv    = 1'b0;
        w_latch  = 1'b0;
        w_accept = 1'b0;
        w_db_clr = 1'b0;
        w_db_inc = 1'b0;
        unique case (r_state)
            SCAN: begin
                w_latch  = w_tick && w_one;
                w_adv    = w_tick && !w_one;
                w_db_clr = w_latch;
            end
            PRESS_DB: begin
                if (!w_match)      w_adv    = 1'b1;
                else if (w_db_max) w_accept = 1'b1;
                else               w_db_inc = 1'b1;
            end
            HELD: w_db_clr = w_idle;
            REL_DB: begin
                if (!w_idle)       w_db_clr = 1'b1;
                else if (w_db_max) w_adv    = 1'b1;
                else               w_db_inc = 1'b1;
            end
            default: ;
        endcase
    end

    // Divider free-runs only while scanning; any other state holds it at 0.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (r_state == SCAN && !w_tick) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div <= '0;
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_db <= '0;
        end else if (w_db_clr) begin
            r_db <= '0;
        end else if (w_db_inc && !w_db_max) begin
            r_db <= r_db + 1'b1;
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_cols     <= COL_FIRST;
            r_cand     <= KEY_NONE;
            r_keypress <= KEY_NONE;
            r_alarm    <= 1'b0;
        end else begin
            if (w_adv)    r_cols     <= {r_cols[2:0], r_cols[3]};
            if (w_latch)  r_cand     <= {~w_rows_s, ~r_cols};
            if (w_accept) r_keypress <= r_cand;
            r_alarm <= w_accept || w_rep_fire;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = cnt_w(REPEAT_CYC);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);

    logic [RW-1:0] r_rep;

    assign w_rep_fire = (r_state == HELD) && (r_rep == REP_MAX);

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_rep <= '0;
        end else if (w_accept || w_rep_fire) begin
            r_rep <= '0;
        end else if (r_state == HELD) begin
            r_rep <= r_rep + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign cols     = r_cols;
    assign keypress = r_keypress;
    assign alarm    = r_alarm;

endmodule

// File: tb/tb_lab3_keypad_scanner.sv
// Directed bench for lab3_keypad_scanner with a behavioural 4x4 key matrix.
// Small parameters: SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=16.
module tb_lab3_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] keypress;
    logic       alarm;

    logic [15:0] keys;
    logic        use_frc;
    logic [3:0]  frc_rows;

    int n_vec;
    int n_err;
    int n_alarm;
    int n_dbl;
    bit prev_al;
    logic [7:0] last_kp;

    lab3_keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8),
        .REPEAT_CYC   (16)
    ) dut (
        .int_osc  (clk),
        .reset    (rst_n),
        .rows     (rows),
        .cols     (cols),
        .keypress (keypress),
        .alarm    (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
        if (use_frc) rows = frc_rows;
    end

    always @(negedge clk) begin
        if (alarm) begin
            n_alarm++;
            last_kp = keypress;
            if (prev_al) n_dbl++;
        end
        prev_al = alarm;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_alarm(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step(1);
            if (alarm) got = 1'b1;
        end
    endtask

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] k;
        k = '0;
        k[r*4+c] = 1'b1;
        return k;
    endfunction

    initial begin
        int a0;
        int bad;
        int chg;
        int exp_rep;
        bit got;
        logic [3:0] pc;

        n_vec = 0; n_err = 0; n_alarm = 0; n_dbl = 0; prev_al = 0;
        last_kp = '0;
        keys = '0; use_frc = 1'b1; frc_rows = 4'hF;
        rst_n = 1'b0;

        // Reset with random rows
        for (int i = 0; i < 4; i++) begin
            frc_rows = 4'($urandom_range(0, 15));
            step(2);
            chk("rst_cols", cols, 4'b1110);
            chk("rst_kp", keypress, 8'h00);
            chk("rst_alarm", alarm, 1'b0);
        end

        // Exact acceptance latency: key (0,0) held through reset release
        use_frc = 1'b0;
        keys = key(0, 0);
        step(1);
        rst_n = 1'b1;
        step(11);
        chk("lat_pre", alarm, 1'b0);
        step(1);
        chk("lat_alarm", alarm, 1'b1);
        chk("lat_kp", keypress, 8'h11);
        step(1);
        chk("lat_single", alarm, 1'b0);
        chk("lat_cols", cols, 4'b1110);
        keys = '0;
        step(30);

        // Clean press row 2 / col 1
        a0 = n_alarm;
        keys = key(2, 1);
        wait_alarm(60, got);
        chk("clean_seen", got, 1'b1);
        chk("clean_cols_acc", cols, 4'b1101);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cols !== 4'b1101) bad++;
        end
        chk("clean_frozen", bad, 0);
        keys = '0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (cols !== 4'b1101) bad++;
        end
        chk("rel_frozen", bad, 0);
        step(1);
        chk("rel_adv", cols, 4'b1011);
        step(2);
        chk("clean_count", n_alarm - a0, 1);
        chk("clean_kp", keypress, 8'h42);

        // Bounce on row 1 / col 3
        a0 = n_alarm;
        for (int i = 0; i < 30; i++) begin
            keys = ((i / 3) % 2 == 0) ? key(1, 3) : 16'h0;
            step(1);
        end
        keys = key(1, 3);
        chk("bounce_quiet", n_alarm - a0, 0);
        wait_alarm(40, got);
        chk("bounce_seen", got, 1'b1);
        step(2);
        chk("bounce_count", n_alarm - a0, 1);
        chk("bounce_kp", keypress, 8'h28);
        keys = '0;
        step(30);

        // Two keys in one column are rejected, scan keeps moving
        a0 = n_alarm;
        keys = key(0, 2) | key(3, 2);
        chg = 0;
        pc = cols;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cols !== pc) chg++;
            pc = cols;
        end
        chk("multi_quiet", n_alarm - a0, 0);
        chk("multi_scan", chg >= 8, 1'b1);
        chk("multi_kp", keypress, 8'h28);
        keys = '0;
        step(20);

        // Second key during HELD is ignored
        a0 = n_alarm;
        keys = key(1, 0);
        wait_alarm(60, got);
        chk("held_seen", got, 1'b1);
        keys = key(1, 0) | key(3, 0);
        step(20);
        chk("held_count", n_alarm - a0, 1);
        chk("held_kp", keypress, 8'h21);
        keys = '0;
        step(30);

        // Reset in the middle of press debounce
        a0 = n_alarm;
        rst_n = 1'b0;
        keys = key(0, 0);
        step(2);
        rst_n = 1'b1;
        step(9);
        rst_n = 1'b0;
        #1;
        chk("mid_kp", keypress, 8'h00);
        chk("mid_alarm", alarm, 1'b0);
        chk("mid_cols", cols, 4'b1110);
        step(3);
        keys = '0;
        rst_n = 1'b1;
        step(3);
        chk("mid_scan0", cols, 4'b1110);
        step(1);
        chk("mid_scan1", cols, 4'b1101);
        step(30);
        chk("mid_quiet", n_alarm - a0, 0);
        chk("mid_kp_after", keypress, 8'h00);

        // Long hold: one strobe, or three with auto-repeat
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rep = 3;
`else
        exp_rep = 1;
`endif
        rst_n = 1'b0;
        keys = key(0, 0);
        step(2);
        a0 = n_alarm;
        rst_n = 1'b1;
        step(12);
        chk("hold_first", alarm, 1'b1);
        step(40);
        keys = '0;
        step(20);
        chk("hold_count", n_alarm - a0, exp_rep);
        chk("hold_kp", last_kp, 8'h11);

        chk("no_double", n_dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
